// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads 16 message words, then streams W[0..ROUNDS-1].
// Optional completed-block counter on blk_cnt when SHA256_SCHED_CNT_EN is defined.
module sha256_msg_sched #(
  parameter int ROUNDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [31:0] w_word,
  output logic [5:0]  w_round,
  output logic        w_last
`ifdef SHA256_SCHED_CNT_EN
  ,
  output logic [15:0] blk_cnt
`endif
);

  localparam int DATA_W = 32;
  localparam logic [5:0] LAST_RND = 6'(ROUNDS - 1);

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [3:0]          ld_cnt;
  logic [5:0]          rnd;
  logic [DATA_W-1:0]   sched_buf [16];
  logic [DATA_W-1:0]   w_nxt;
  logic                ld_fire;
  logic                w_fire;
  logic                blk_done;

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input int n);
    return (x >> n) | (x << (DATA_W - n));
  endfunction

  function automatic logic [DATA_W-1:0] sig0(input logic [DATA_W-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [DATA_W-1:0] sig1(input logic [DATA_W-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Window buf[0..15] = W[t..t+15], so W[t+16] needs only fixed taps.
  assign w_nxt = sig1(sched_buf[14]) + sched_buf[9] + sig0(sched_buf[1]) + sched_buf[0];

  always_comb begin
    state_nxt = state;
    ld_fire   = 1'b0;
    w_fire    = 1'b0;
    blk_done  = 1'b0;
    case (state)
      LOAD: begin
        ld_fire = in_valid;
        if (in_valid && (ld_cnt == 4'd15)) state_nxt = RUN;
      end
      RUN: begin
        w_fire = w_ready;
        if (w_ready && (rnd == LAST_RND)) begin
          blk_done  = 1'b1;
          state_nxt = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  assign in_ready = (state == LOAD);
  assign w_valid  = (state == RUN);
  assign w_word   = w_valid ? sched_buf[0] : '0;
  assign w_round  = w_valid ? rnd : 6'd0;
  assign w_last   = w_valid && (rnd == LAST_RND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= LOAD;
      ld_cnt <= 4'd0;
      rnd    <= 6'd0;
    end else begin
      state <= state_nxt;
      if (ld_fire) begin
        ld_cnt <= ld_cnt + 4'd1;
        if (ld_cnt == 4'd15) rnd <= 6'd0;
      end
      if (w_fire) rnd <= blk_done ? 6'd0 : rnd + 6'd1;
    end
  end

  // Partial blocks are discarded on reset, so the window is cleared too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) sched_buf[i] <= '0;
    end else if (ld_fire) begin
      sched_buf[ld_cnt] <= in_word;
    end else if (w_fire) begin
      for (int i = 0; i < 15; i++) sched_buf[i] <= sched_buf[i+1];
      sched_buf[15] <= w_nxt;
    end
  end

`ifdef SHA256_SCHED_CNT_EN
  logic [15:0] blk_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        blk_cnt_q <= 16'd0;
    else if (blk_done) blk_cnt_q <= blk_cnt_q + 16'd1;
  end

  assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed bench for sha256_msg_sched: abc block, backpressure, input gaps,
// mid-block reset, back-to-back blocks and modular-add wrap.
module tb_sha256_msg_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_word = 32'd0;
  logic        w_valid;
  logic        w_ready = 1'b0;
  logic [31:0] w_word;
  logic [5:0]  w_round;
  logic        w_last;
`ifdef SHA256_SCHED_CNT_EN
  logic [15:0] blk_cnt;
`endif

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] msg   [16];
  logic [31:0] exp_w [64];

  sha256_msg_sched #(.ROUNDS(64)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_word  (in_word),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .w_word   (w_word),
    .w_round  (w_round),
    .w_last   (w_last)
`ifdef SHA256_SCHED_CNT_EN
    ,
    .blk_cnt  (blk_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] ref_sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
  endfunction

  // FIPS 180-4 recurrence over the whole array.
  task automatic compute_exp();
    for (int t = 0; t < 16; t++) exp_w[t] = msg[t];
    for (int t = 16; t < 64; t++)
      exp_w[t] = ref_sig1(exp_w[t-2]) + exp_w[t-7] + ref_sig0(exp_w[t-15]) + exp_w[t-16];
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) msg[i] = 32'd0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
  endtask

  // Drives one block from the current negedge; ends on the negedge after the 16th handshake.
  task automatic load_block(input bit gaps);
    int  i = 0;
    int  guard = 0;
    bit  hs;
    while (i < 16 && guard < 300) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_word  = 32'h0BAD0BAD;
      end else begin
        in_valid = 1'b1;
        in_word  = msg[i];
      end
      hs = in_valid && in_ready;
      @(negedge clk);
      guard++;
      if (hs) i++;
    end
    in_valid = 1'b0;
    in_word  = 32'd0;
    n_total++;
    if (i != 16) $display("FAIL load_timeout: loaded %0d words, required 16", i);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if (w_valid !== 1'b0) $display("FAIL reset_w_valid: got %b want 0", w_valid); else n_pass++;
    n_total++;
    if (w_word !== 32'd0) $display("FAIL reset_w_word: got %h want 0", w_word); else n_pass++;
    n_total++;
    if (w_round !== 6'd0) $display("FAIL reset_w_round: got %0d want 0", w_round); else n_pass++;
    n_total++;
    if (w_last !== 1'b0) $display("FAIL reset_w_last: got %b want 0", w_last); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
`ifdef SHA256_SCHED_CNT_EN
    n_total++;
    if (blk_cnt !== 16'd0) $display("FAIL reset_blk_cnt: got %h want 0", blk_cnt); else n_pass++;
`endif
  endtask

  task automatic test_abc();
    int t = 0;
    int cyc = 0;
    set_abc();
    compute_exp();
    load_block(1'b0);
    n_total++;
    if (w_valid !== 1'b1) $display("FAIL abc_latency: w_valid=%b want 1", w_valid); else n_pass++;
    w_ready = 1'b1;
    while (t < 64 && cyc < 200) begin
      n_total++;
      if (w_word !== exp_w[t]) $display("FAIL abc_word t=%0d: got %h want %h", t, w_word, exp_w[t]);
      else n_pass++;
      n_total++;
      if (w_round !== 6'(t) || w_last !== (t == 63))
        $display("FAIL abc_round t=%0d: round %0d last %b", t, w_round, w_last);
      else n_pass++;
      if (t == 0 || t == 15 || t == 16 || t == 17) begin
        n_total++;
        if (w_word !== (t == 15 ? 32'h00000018 : (t == 17 ? 32'h000F0000 : 32'h61626380)))
          $display("FAIL abc_known t=%0d: got %h", t, w_word);
        else n_pass++;
      end
      @(negedge clk);
      cyc++;
      if (w_ready) t++;
    end
    n_total++;
    if (t != 64) $display("FAIL abc_timeout: got %0d words want 64", t); else n_pass++;
    n_total++;
    if (in_ready !== 1'b1 || w_valid !== 1'b0)
      $display("FAIL abc_after: in_ready=%b w_valid=%b want 1/0", in_ready, w_valid);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int t = 0;
    int cyc = 0;
    int stall = 0;
    set_abc();
    compute_exp();
    w_ready = 1'b0;
    load_block(1'b0);
    while (t < 64 && cyc < 400) begin
      if (t == 20 && stall < 5) begin
        w_ready = 1'b0;
        stall++;
      end else begin
        w_ready = (cyc % 2 == 0);
      end
      n_total++;
      if (w_valid !== 1'b1 || w_word !== exp_w[t] || w_round !== 6'(t))
        $display("FAIL bp_word t=%0d: valid %b word %h round %0d want %h", t, w_valid, w_word, w_round, exp_w[t]);
      else n_pass++;
      @(negedge clk);
      cyc++;
      if (w_ready) t++;
    end
    n_total++;
    if (t != 64 || stall != 5) $display("FAIL bp_timeout: words %0d stalls %0d", t, stall); else n_pass++;
    w_ready = 1'b1;
  endtask

  task automatic test_input_gaps();
    int t = 0;
    int cyc = 0;
    set_abc();
    compute_exp();
    load_block(1'b1);
    w_ready  = 1'b1;
    while (t < 64 && cyc < 200) begin
      in_valid = 1'b1;
      in_word  = 32'hDEADBEEF;
      n_total++;
      if (in_ready !== 1'b0) $display("FAIL gaps_in_ready t=%0d: got %b want 0", t, in_ready); else n_pass++;
      n_total++;
      if (w_word !== exp_w[t] || w_last !== (t == 63))
        $display("FAIL gaps_word t=%0d: got %h want %h", t, w_word, exp_w[t]);
      else n_pass++;
      @(negedge clk);
      cyc++;
      if (w_ready) t++;
    end
    in_valid = 1'b0;
    in_word  = 32'd0;
    n_total++;
    if (t != 64) $display("FAIL gaps_timeout: got %0d words", t); else n_pass++;
  endtask

  task automatic test_reset_mid_block();
    int t = 0;
    int cyc = 0;
    set_abc();
    compute_exp();
    load_block(1'b0);
    w_ready = 1'b1;
    while (t < 30 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      t++;
    end
    n_total++;
    if (w_round !== 6'd30) $display("FAIL mid_pre_round: got %0d want 30", w_round); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (w_valid !== 1'b0 || w_word !== 32'd0 || w_round !== 6'd0 || w_last !== 1'b0)
      $display("FAIL mid_reset: valid %b word %h round %0d last %b", w_valid, w_word, w_round, w_last);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL mid_in_ready: got %b want 1", in_ready); else n_pass++;
    load_block(1'b0);
    t = 0;
    cyc = 0;
    while (t < 64 && cyc < 200) begin
      n_total++;
      if (w_word !== exp_w[t] || w_round !== 6'(t))
        $display("FAIL mid_word t=%0d: got %h want %h", t, w_word, exp_w[t]);
      else n_pass++;
      @(negedge clk);
      cyc++;
      t++;
    end
  endtask

  task automatic test_back_to_back();
    int t;
    int cyc;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    w_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      if (b == 0) set_abc();
      else for (int i = 0; i < 16; i++) msg[i] = 32'h01234567 ^ (32'(i) * 32'h11111111);
      compute_exp();
      load_block(1'b0);
      t = 0;
      cyc = 0;
      while (t < 64 && cyc < 200) begin
        n_total++;
        if (w_word !== exp_w[t] || w_last !== (t == 63))
          $display("FAIL b2b_word blk=%0d t=%0d: got %h want %h", b, t, w_word, exp_w[t]);
        else n_pass++;
        @(negedge clk);
        cyc++;
        t++;
      end
      n_total++;
      if (in_ready !== 1'b1) $display("FAIL b2b_in_ready blk=%0d: got %b want 1", b, in_ready); else n_pass++;
    end
`ifdef SHA256_SCHED_CNT_EN
    n_total++;
    if (blk_cnt !== 16'd2) $display("FAIL b2b_blk_cnt: got %0d want 2", blk_cnt); else n_pass++;
    force dut.blk_cnt_q = 16'hFFFF;
    #1;
    release dut.blk_cnt_q;
    load_block(1'b0);
    repeat (64) @(negedge clk);
    n_total++;
    if (blk_cnt !== 16'h0000) $display("FAIL b2b_wrap: got %h want 0000", blk_cnt); else n_pass++;
`endif
  endtask

  task automatic test_modular_add();
    int t = 0;
    int cyc = 0;
    for (int i = 0; i < 16; i++) msg[i] = 32'hFFFFFFFF;
    compute_exp();
    load_block(1'b0);
    w_ready = 1'b1;
    while (t < 64 && cyc < 200) begin
      n_total++;
      if (w_word !== exp_w[t]) $display("FAIL modadd_word t=%0d: got %h want %h", t, w_word, exp_w[t]);
      else n_pass++;
      if (t == 16) begin
        n_total++;
        if (w_word !== 32'h203FFFFC) $display("FAIL modadd_w16: got %h want 203ffffc", w_word);
        else n_pass++;
      end
      @(negedge clk);
      cyc++;
      t++;
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_backpressure();
    test_input_gaps();
    test_reset_mid_block();
    test_back_to_back();
    test_modular_add();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
